// File: rtl/sht40_convert_pkg.sv
// Shared definitions for the SHT40 raw-to-fixed-point converter.
// Contents: FSM state encoding, rounding constant, RH clamp limit, Fahrenheit
// pass constants and the round/offset helper used by the SCALE step.
package sht40_convert_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MUL   = 2'd1,
        ST_SCALE = 2'd2,
        ST_DONE  = 2'd3
    } conv_state_t;

    // Half of 2^16, added before the >>16 so the result rounds to nearest
    localparam logic [31:0] ROUND_CONST = 32'd32768;

    // Upper bound for the humidity result, centi-%RH
    localparam logic signed [16:0] RH_LIMIT = 17'sd10000;

    // Second temperature pass: converts the same raw word to centi-degF
    localparam logic [15:0]        F_SCALE  = 16'd31500;
    localparam logic signed [16:0] F_OFFSET = -17'sd4900;

    // Round the 32-bit product to its upper 16 bits and add the signed offset.
    // The rounded quotient never exceeds 31500, so 17 signed bits are enough.
    function automatic logic signed [16:0] scale_round(
        input logic [31:0]        product,
        input logic signed [16:0] offset
    );
        logic [31:0] rounded;
        rounded = (product + ROUND_CONST) >> 16;
        return signed'(17'(rounded)) + offset;
    endfunction

endpackage

// File: rtl/sht40_convert_mul16.sv
// 16x16 unsigned serial shift-add multiplier, one multiplier bit per cycle,
// LSB first.
// Ports:
//   clk          in   system clock
//   rst_n        in   synchronous active-low reset
//   start        in   load operands and begin a 16-cycle multiply
//   multiplicand in   16-bit operand that is shifted left each step
//   multiplier   in   16-bit operand consumed one bit per step
//   done         out  high during the final accumulate step
//   product      out  32-bit result, final in the cycle after done
module sht40_convert_mul16 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] multiplicand,
    input  logic [15:0] multiplier,
    output logic        done,
    output logic [31:0] product
);

    logic [31:0] mcand;
    logic [15:0] mplier;
    logic [31:0] acc;
    logic [3:0]  count;
    logic        busy;

    // Each busy cycle adds the shifted multiplicand when the current
    // multiplier LSB is set; after 16 steps every bit has been consumed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            count  <= '0;
            busy   <= 1'b0;
        end else if (start) begin
            mcand  <= {16'd0, multiplicand};
            mplier <= multiplier;
            acc    <= '0;
            count  <= '0;
            busy   <= 1'b1;
        end else if (busy) begin
            if (mplier[0]) begin
                acc <= acc + mcand;
            end
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + 4'd1;
            if (count == 4'd15) begin
                busy <= 1'b0;
            end
        end
    end

    // done marks the last step so the caller can move on with no gap; the
    // accumulator holds the full product from the next cycle on.
    assign done    = busy && (count == 4'd15);
    assign product = acc;

endmodule

// File: rtl/sht40_convert.sv
// Converts raw SHT40 temperature / humidity words into signed centi-degC and
// unsigned centi-%RH using one shared serial multiplier, and reports each
// result with a single-cycle valid pulse.
// Optional feature macro: SHT_CONV_FAHR_EN adds Temp_F_Centi and a second
// multiply pass for Fahrenheit; Temp_Valid then fires after both passes.
// Ports:
//   clk, Reset_N                    clock, synchronous active-low reset
//   Temperature_Output/Temp_Ready_Out  raw S_T word and its ready pulse
//   Humidity_Output/RH_Ready_Out       raw S_RH word and its ready pulse
//   CRC_Error_Out                   high drops any sample readied this cycle
//   Temp_Centi/Temp_Valid           signed centi-degC result and pulse
//   RH_Centi/RH_Valid               unsigned centi-%RH result and pulse
//   Temp_F_Centi                    signed centi-degF (SHT_CONV_FAHR_EN only)
//   Conv_Busy                       converter outside IDLE
//   Overrun                         sticky, a pending sample was overwritten
module sht40_convert
    import sht40_convert_pkg::*;
#(
    parameter int T_SCALE   = 17500,
    parameter int T_OFFSET  = -4500,
    parameter int RH_SCALE  = 12500,
    parameter int RH_OFFSET = -600,
    parameter int RH_CLAMP  = 1
) (
    input  logic        clk,
    input  logic        Reset_N,
    input  logic [15:0] Temperature_Output,
    input  logic [15:0] Humidity_Output,
    input  logic        Temp_Ready_Out,
    input  logic        RH_Ready_Out,
    input  logic        CRC_Error_Out,
    output logic [15:0] Temp_Centi,
    output logic        Temp_Valid,
    output logic [15:0] RH_Centi,
    output logic        RH_Valid,
    output logic        Conv_Busy,
`ifdef SHT_CONV_FAHR_EN
    output logic [15:0] Temp_F_Centi,
`endif
    output logic        Overrun
);

    localparam logic [15:0]        T_SCALE_W  = 16'(T_SCALE);
    localparam logic [15:0]        RH_SCALE_W = 16'(RH_SCALE);
    localparam logic signed [16:0] T_OFF_W    = 17'(T_OFFSET);
    localparam logic signed [16:0] RH_OFF_W   = 17'(RH_OFFSET);

    conv_state_t state, next_state;

    logic [15:0] pending_t, pending_rh;
    logic        flag_t, flag_rh;
    logic        cap_t, cap_rh;
    logic        take_t, take_rh;
    logic        cur_rh;
    logic        launch;

    logic        mul_start, mul_done;
    logic [15:0] mul_mcand, mul_mplier;
    logic [31:0] mul_product;

    logic signed [16:0] pass_offset;
    logic signed [16:0] scaled;
    logic [15:0]        rh_result;

`ifdef SHT_CONV_FAHR_EN
    logic        f_pass;
    logic        fahr_start;
    logic [15:0] cur_sample;
    logic [15:0] temp_c_hold;
`endif

    assign cap_t  = Temp_Ready_Out & ~CRC_Error_Out;
    assign cap_rh = RH_Ready_Out & ~CRC_Error_Out;

    sht40_convert_mul16 u_mul (
        .clk          (clk),
        .rst_n        (Reset_N),
        .start        (mul_start),
        .multiplicand (mul_mcand),
        .multiplier   (mul_mplier),
        .done         (mul_done),
        .product      (mul_product)
    );

    // Next-state and output decode. Both IDLE and the final DONE cycle can
    // launch a new conversion, so a queued RH sample follows a temperature
    // result with no idle gap. Temperature always wins the selection.
    always_comb begin
        next_state = state;
        launch     = 1'b0;
        mul_start  = 1'b0;
        take_t     = 1'b0;
        take_rh    = 1'b0;
        mul_mcand  = T_SCALE_W;
        mul_mplier = pending_t;
        Temp_Valid = 1'b0;
        RH_Valid   = 1'b0;
        Conv_Busy  = (state != ST_IDLE);
`ifdef SHT_CONV_FAHR_EN
        fahr_start = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                launch = 1'b1;
            end
            ST_MUL: begin
                if (mul_done) begin
                    next_state = ST_SCALE;
                end
            end
            ST_SCALE: begin
                next_state = ST_DONE;
            end
            ST_DONE: begin
`ifdef SHT_CONV_FAHR_EN
                if (!cur_rh && !f_pass) begin
                    fahr_start = 1'b1;
                    mul_start  = 1'b1;
                    mul_mcand  = F_SCALE;
                    mul_mplier = cur_sample;
                    next_state = ST_MUL;
                end else begin
                    Temp_Valid = ~cur_rh;
                    RH_Valid   = cur_rh;
                    next_state = ST_IDLE;
                    launch     = 1'b1;
                end
`else
                Temp_Valid = ~cur_rh;
                RH_Valid   = cur_rh;
                next_state = ST_IDLE;
                launch     = 1'b1;
`endif
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase

        if (launch) begin
            if (flag_t) begin
                take_t     = 1'b1;
                mul_start  = 1'b1;
                mul_mcand  = T_SCALE_W;
                mul_mplier = pending_t;
                next_state = ST_MUL;
            end else if (flag_rh) begin
                take_rh    = 1'b1;
                mul_start  = 1'b1;
                mul_mcand  = RH_SCALE_W;
                mul_mplier = pending_rh;
                next_state = ST_MUL;
            end
        end
    end

    // Offset for the pass currently in the multiplier, then round/offset and
    // the optional humidity clamp.
    always_comb begin
        pass_offset = cur_rh ? RH_OFF_W : T_OFF_W;
`ifdef SHT_CONV_FAHR_EN
        if (!cur_rh && f_pass) begin
            pass_offset = F_OFFSET;
        end
`endif
        scaled    = scale_round(mul_product, pass_offset);
        rh_result = scaled[15:0];
        if (RH_CLAMP != 0) begin
            if (scaled < 17'sd0) begin
                rh_result = 16'd0;
            end else if (scaled > RH_LIMIT) begin
                rh_result = RH_LIMIT[15:0];
            end
        end
    end

    // State, capture registers and results. A capture in the same cycle the
    // channel is selected keeps its flag set, so the new sample is converted
    // next; that case is not an overrun because the old sample was consumed.
    always_ff @(posedge clk) begin
        if (!Reset_N) begin
            state       <= ST_IDLE;
            pending_t   <= '0;
            pending_rh  <= '0;
            flag_t      <= 1'b0;
            flag_rh     <= 1'b0;
            cur_rh      <= 1'b0;
            Temp_Centi  <= '0;
            RH_Centi    <= '0;
            Overrun     <= 1'b0;
`ifdef SHT_CONV_FAHR_EN
            f_pass       <= 1'b0;
            cur_sample   <= '0;
            temp_c_hold  <= '0;
            Temp_F_Centi <= '0;
`endif
        end else begin
            state <= next_state;

            if (cap_t) begin
                pending_t <= Temperature_Output;
                flag_t    <= 1'b1;
                if (flag_t && !take_t) begin
                    Overrun <= 1'b1;
                end
            end else if (take_t) begin
                flag_t <= 1'b0;
            end

            if (cap_rh) begin
                pending_rh <= Humidity_Output;
                flag_rh    <= 1'b1;
                if (flag_rh && !take_rh) begin
                    Overrun <= 1'b1;
                end
            end else if (take_rh) begin
                flag_rh <= 1'b0;
            end

            if (mul_start) begin
`ifdef SHT_CONV_FAHR_EN
                if (fahr_start) begin
                    f_pass <= 1'b1;
                end else begin
                    f_pass     <= 1'b0;
                    cur_sample <= mul_mplier;
                    cur_rh     <= take_rh;
                end
`else
                cur_rh <= take_rh;
`endif
            end

            if (state == ST_SCALE) begin
                if (cur_rh) begin
                    RH_Centi <= rh_result;
                end else begin
`ifdef SHT_CONV_FAHR_EN
                    if (!f_pass) begin
                        temp_c_hold <= scaled[15:0];
                    end else begin
                        Temp_Centi   <= temp_c_hold;
                        Temp_F_Centi <= scaled[15:0];
                    end
`else
                    Temp_Centi <= scaled[15:0];
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_sht40_convert.sv
// Self-checking bench for sht40_convert: directed scenarios plus randomized
// samples checked against an arithmetic reference model.
module tb_sht40_convert;

    logic        clk = 1'b0;
    logic        Reset_N;
    logic [15:0] Temperature_Output;
    logic [15:0] Humidity_Output;
    logic        Temp_Ready_Out;
    logic        RH_Ready_Out;
    logic        CRC_Error_Out;
    logic [15:0] Temp_Centi;
    logic        Temp_Valid;
    logic [15:0] RH_Centi;
    logic        RH_Valid;
    logic        Conv_Busy;
    logic        Overrun;
`ifdef SHT_CONV_FAHR_EN
    logic [15:0] Temp_F_Centi;
    localparam int TLAT = 37;
`else
    localparam int TLAT = 19;
`endif

    int tests_run    = 0;
    int tests_failed = 0;
    int last_rh_exp  = 0;

    always #5 clk = ~clk;

    sht40_convert dut (
        .clk                (clk),
        .Reset_N            (Reset_N),
        .Temperature_Output (Temperature_Output),
        .Humidity_Output    (Humidity_Output),
        .Temp_Ready_Out     (Temp_Ready_Out),
        .RH_Ready_Out       (RH_Ready_Out),
        .CRC_Error_Out      (CRC_Error_Out),
        .Temp_Centi         (Temp_Centi),
        .Temp_Valid         (Temp_Valid),
        .RH_Centi           (RH_Centi),
        .RH_Valid           (RH_Valid),
        .Conv_Busy          (Conv_Busy),
`ifdef SHT_CONV_FAHR_EN
        .Temp_F_Centi       (Temp_F_Centi),
`endif
        .Overrun            (Overrun)
    );

    // Reference conversion straight from the datasheet formula with rounding
    function automatic int model_conv(input int scale, input int offset, input int s, input bit clamp);
        longint r;
        r = ((longint'(scale) * longint'(s) + 32768) >>> 16) + offset;
        if (clamp) begin
            if (r < 0) r = 0;
            else if (r > 10000) r = 10000;
        end
        return int'(r);
    endfunction

    function automatic int model_t(input int s);
        return model_conv(17500, -4500, s, 1'b0);
    endfunction

    function automatic int model_f(input int s);
        return model_conv(31500, -4900, s, 1'b0);
    endfunction

    function automatic int model_rh(input int s);
        return model_conv(12500, -600, s, 1'b1);
    endfunction

    // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
        Temp_Ready_Out = 1'b0;
        RH_Ready_Out   = 1'b0;
        CRC_Error_Out  = 1'b0;
    endtask

    task automatic pulse(input bit do_t, input bit do_rh, input logic [15:0] t,
                         input logic [15:0] rh, input bit crc);
        Temperature_Output = t;
        Humidity_Output    = rh;
        Temp_Ready_Out     = do_t;
        RH_Ready_Out       = do_rh;
        CRC_Error_Out      = crc;
    endtask

    // Returns cycles until the requested valid pulse, or -1 when the budget expires
    task automatic wait_valid(input bit rh, input int budget, output int lat);
        lat = -1;
        for (int i = 1; i <= budget; i++) begin
            step();
            if (rh ? RH_Valid : Temp_Valid) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        Reset_N = 1'b0;
        pulse(1'b1, 1'b1, 16'h1234, 16'h5678, 1'b0);
        repeat (3) step();
        tests_run++;
        if (Temp_Centi !== 16'd0 || RH_Centi !== 16'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_data: temp=%h rh=%h required 0/0", Temp_Centi, RH_Centi);
        end
        tests_run++;
        if ({Temp_Valid, RH_Valid, Conv_Busy, Overrun} !== 4'b0000) begin
            tests_failed++;
            $display("[TB] FAIL reset_flags: tv/rv/busy/ovr=%b required 0000",
                     {Temp_Valid, RH_Valid, Conv_Busy, Overrun});
        end
        Reset_N = 1'b1;
        step();
        step();
        tests_run++;
        if (Conv_Busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_no_capture: busy=%b required 0", Conv_Busy);
        end
    endtask

    task automatic test_temp_basic();
        int lat;
        pulse(1'b1, 1'b0, 16'h6666, 16'h0000, 1'b0);
        wait_valid(1'b0, 80, lat);
        tests_run++;
        if (lat != TLAT) begin
            tests_failed++;
            $display("[TB] FAIL basic_latency: got %0d cycles required %0d", lat, TLAT);
        end
        tests_run++;
        if (Temp_Centi !== 16'd2500) begin
            tests_failed++;
            $display("[TB] FAIL basic_temp: got %0d required 2500", $signed(Temp_Centi));
        end
`ifdef SHT_CONV_FAHR_EN
        tests_run++;
        if (Temp_F_Centi !== 16'd7700) begin
            tests_failed++;
            $display("[TB] FAIL basic_fahr: got %0d required 7700", $signed(Temp_F_Centi));
        end
`endif
        tests_run++;
        if (Conv_Busy !== 1'b1 || RH_Valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL basic_done_flags: busy=%b rv=%b required 1/0", Conv_Busy, RH_Valid);
        end
        step();
        tests_run++;
        if (Temp_Valid !== 1'b0 || Conv_Busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL basic_single_pulse: tv=%b busy=%b required 0/0", Temp_Valid, Conv_Busy);
        end
    endtask

    task automatic test_simultaneous();
        int lat;
        pulse(1'b1, 1'b1, 16'hBEEF, 16'hABCD, 1'b0);
        wait_valid(1'b0, 80, lat);
        tests_run++;
        if (lat != TLAT || Temp_Centi !== 16'd8552) begin
            tests_failed++;
            $display("[TB] FAIL simul_temp: lat=%0d val=%0d required %0d/8552", lat, $signed(Temp_Centi), TLAT);
        end
`ifdef SHT_CONV_FAHR_EN
        tests_run++;
        if (Temp_F_Centi !== 16'(model_f(16'hBEEF))) begin
            tests_failed++;
            $display("[TB] FAIL simul_fahr: got %0d required %0d", $signed(Temp_F_Centi), model_f(16'hBEEF));
        end
`endif
        wait_valid(1'b1, 80, lat);
        tests_run++;
        if (lat != 18 || RH_Centi !== 16'd7789) begin
            tests_failed++;
            $display("[TB] FAIL simul_rh: lat=%0d val=%0d required 18/7789", lat, RH_Centi);
        end
        last_rh_exp = 7789;
        tests_run++;
        if (Overrun !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL simul_overrun: got %b required 0", Overrun);
        end
        step();
    endtask

    task automatic test_boundaries();
        bit          b_rh  [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic [15:0] b_s   [4] = '{16'h0000, 16'hFFFF, 16'hFFFF, 16'h0000};
        logic [15:0] b_exp [4] = '{16'd0, 16'd10000, 16'd13000, 16'hEE6C};
        int lat;
        for (int i = 0; i < 4; i++) begin
            pulse(~b_rh[i], b_rh[i], b_s[i], b_s[i], 1'b0);
            wait_valid(b_rh[i], 80, lat);
            tests_run++;
            if ((b_rh[i] ? RH_Centi : Temp_Centi) !== b_exp[i] || lat != (b_rh[i] ? 19 : TLAT)) begin
                tests_failed++;
                $display("[TB] FAIL boundary_%0d: got %h lat %0d required %h", i,
                         b_rh[i] ? RH_Centi : Temp_Centi, lat, b_exp[i]);
            end
            if (b_rh[i]) last_rh_exp = int'(b_exp[i]);
            step();
        end
    endtask

    task automatic test_crc_drop();
        int lat;
        pulse(1'b0, 1'b1, 16'h0000, 16'h1234, 1'b1);
        wait_valid(1'b1, 45, lat);
        tests_run++;
        if (lat != -1 || RH_Centi !== 16'(last_rh_exp)) begin
            tests_failed++;
            $display("[TB] FAIL crc_drop: pulse at %0d rh=%0d required none/%0d", lat, RH_Centi, last_rh_exp);
        end
    endtask

    task automatic test_overrun();
        int lat;
        logic [15:0] v;
        pulse(1'b0, 1'b1, 16'h0000, 16'h8000, 1'b0);
        repeat (3) step();
        for (int k = 0; k < 3; k++) begin
            v = 16'($urandom_range(0, 65535));
            pulse(1'b1, 1'b0, v, 16'h0000, 1'b0);
            step();
            step();
        end
        wait_valid(1'b1, 40, lat);
        tests_run++;
        if (RH_Centi !== 16'(model_rh(16'h8000))) begin
            tests_failed++;
            $display("[TB] FAIL overrun_rh: got %0d required %0d", RH_Centi, model_rh(16'h8000));
        end
        wait_valid(1'b0, 80, lat);
        tests_run++;
        if (lat != TLAT - 1 || Temp_Centi !== 16'(model_t(int'(v)))) begin
            tests_failed++;
            $display("[TB] FAIL overrun_last_value: lat=%0d got %0d required %0d/%0d",
                     lat, $signed(Temp_Centi), TLAT - 1, model_t(int'(v)));
        end
        tests_run++;
        if (Overrun !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL overrun_sticky: got %b required 1", Overrun);
        end
        step();
        Reset_N = 1'b0;
        step();
        Reset_N = 1'b1;
        tests_run++;
        if (Overrun !== 1'b0 || Temp_Centi !== 16'd0) begin
            tests_failed++;
            $display("[TB] FAIL overrun_clear: ovr=%b temp=%0d required 0/0", Overrun, Temp_Centi);
        end
        last_rh_exp = 0;
    endtask

    task automatic test_reset_mid_mul();
        int lat;
        pulse(1'b1, 1'b0, 16'h1111, 16'h0000, 1'b0);
        repeat (8) step();
        Reset_N = 1'b0;
        step();
        Reset_N = 1'b1;
        wait_valid(1'b0, 40, lat);
        tests_run++;
        if (lat != -1 || Temp_Centi !== 16'd0 || RH_Centi !== 16'd0 || Conv_Busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL mid_reset: pulse at %0d temp=%0d rh=%0d busy=%b required none/0/0/0",
                     lat, Temp_Centi, RH_Centi, Conv_Busy);
        end
        last_rh_exp = 0;
        pulse(1'b1, 1'b0, 16'h6666, 16'h0000, 1'b0);
        wait_valid(1'b0, 80, lat);
        tests_run++;
        if (lat != TLAT || Temp_Centi !== 16'd2500) begin
            tests_failed++;
            $display("[TB] FAIL mid_reset_recover: lat=%0d got %0d required %0d/2500", lat, $signed(Temp_Centi), TLAT);
        end
        step();
    endtask

    task automatic test_random();
        int lat;
        int mode;
        logic [15:0] st, srh;
        for (int i = 0; i < 16; i++) begin
            st   = 16'($urandom_range(0, 65535));
            srh  = 16'($urandom_range(0, 65535));
            mode = int'($urandom_range(0, 2));
            pulse(mode != 1, mode != 0, st, srh, 1'b0);
            if (mode != 1) begin
                wait_valid(1'b0, 80, lat);
                tests_run++;
                if (lat != TLAT || Temp_Centi !== 16'(model_t(int'(st)))) begin
                    tests_failed++;
                    $display("[TB] FAIL random_temp_%0d: s=%h lat=%0d got %0d required %0d",
                             i, st, lat, $signed(Temp_Centi), model_t(int'(st)));
                end
`ifdef SHT_CONV_FAHR_EN
                tests_run++;
                if (Temp_F_Centi !== 16'(model_f(int'(st)))) begin
                    tests_failed++;
                    $display("[TB] FAIL random_fahr_%0d: got %0d required %0d",
                             i, $signed(Temp_F_Centi), model_f(int'(st)));
                end
`endif
            end
            if (mode != 0) begin
                wait_valid(1'b1, 80, lat);
                tests_run++;
                if (lat != (mode == 2 ? 18 : 19) || RH_Centi !== 16'(model_rh(int'(srh)))) begin
                    tests_failed++;
                    $display("[TB] FAIL random_rh_%0d: s=%h lat=%0d got %0d required %0d",
                             i, srh, lat, RH_Centi, model_rh(int'(srh)));
                end
            end
            step();
        end
    endtask

    initial begin
        Reset_N            = 1'b0;
        Temperature_Output = '0;
        Humidity_Output    = '0;
        Temp_Ready_Out     = 1'b0;
        RH_Ready_Out       = 1'b0;
        CRC_Error_Out      = 1'b0;
        step();
        test_reset();
        test_temp_basic();
        test_simultaneous();
        test_boundaries();
        test_crc_drop();
        test_overrun();
        test_reset_mid_mul();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
